div_job_controller: RTL and testbench

Job sequencer that sits in front of and behind `fixed_point_division`. It buffers operand pairs from a valid/ready source in a 2-entry FIFO and issues each one to the divider using the `ld_a`/`ld_b` → `loading_done` → `start` pulse protocol. It then waits for the divider's completion carry-out and returns `Q`/`ov`/`dvz` on a valid/ready result port. A per-job timeout recovers a hung divider by pulsing the divider's active-high reset.

---
 rtl/div_job_pkg.sv | 17 +
 rtl/div_job_fifo.sv | 78 +++++++
 rtl/div_job_controller.sv | 216 +++++++++++++++++++++
 tb/tb_div_job_controller.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_job_pkg.sv
// Shared types and constants for the divider job controller.
package div_job_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LDONE,
        ST_START,
        ST_WAIT,
        ST_ABORT
    } div_job_state_t;

    localparam int DIV_W      = 10;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 8;

endpackage

// File: rtl/div_job_fifo.sv
// Two-entry operand FIFO. There is no bypass from din to dout, so a pushed
// entry becomes visible at the head on the cycle after the push. The full
// flag is registered from the next occupancy so in_ready has no
// combinational path from the push/pop requests.
module div_job_fifo
    import div_job_pkg::*;
#(
    parameter int W = 2 * DIV_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [FIFO_DEPTH];
    logic [W-1:0] mem_d [FIFO_DEPTH];
    logic [1:0]   count_q, count_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         full_q, full_d;
    logic         do_push, do_pop;

    // Next-state for storage, pointers, occupancy and the registered full flag.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full_q;
        do_pop   = pop && (count_q != 2'd0);

        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        full_d = (count_d == 2'(FIFO_DEPTH));
    end

    // Control state: cleared by reset so the FIFO restarts empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // Entry storage: contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/div_job_controller.sv
// Job sequencer wrapped around fixed_point_division: queues operand pairs,
// drives the ld_a/ld_b -> loading_done -> start pulse protocol, waits for the
// divider carry-out and presents the result on a valid/ready port. A hung
// divider is recovered by a per-job timeout that pulses div_rst.
// Optional feature macro: DIV_JOB_DVZ_BYPASS_EN (zero divisors answered
// locally without launching the divider).
module div_job_controller
    import div_job_pkg::*;
#(
    parameter int WIDTH          = DIV_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             div_ld_a,
    output logic             div_ld_b,
    output logic             div_loading_done,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    output logic             div_rst,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_q,
    input  logic             div_ov,
    input  logic             div_dvz,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_q,
    output logic             res_ov,
    output logic             res_dvz,
    output logic             res_to,
    output logic [7:0]       job_count
);

    div_job_state_t       state_q, state_d;
    logic                 div_ld_q, div_ld_d;
    logic                 ldone_q, ldone_d;
    logic                 start_q, start_d;
    logic                 div_rst_q, div_rst_d;
    logic [WIDTH-1:0]     div_a_q, div_a_d;
    logic [WIDTH-1:0]     div_b_q, div_b_d;
    logic [CNT_W-1:0]     tmo_q, tmo_d;
    logic                 res_valid_q, res_valid_d;
    logic [WIDTH-1:0]     res_q_q, res_q_d;
    logic                 res_ov_q, res_ov_d;
    logic                 res_dvz_q, res_dvz_d;
    logic                 res_to_q, res_to_d;
    logic [CNT_W-1:0]     job_count_q, job_count_d;

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2*WIDTH-1:0]   fifo_dout;
    logic [WIDTH-1:0]     head_a, head_b;
    logic                 bypass;

    assign fifo_push = in_valid && !fifo_full;
    assign in_ready  = !fifo_full;
    assign head_a    = fifo_dout[2*WIDTH-1:WIDTH];
    assign head_b    = fifo_dout[WIDTH-1:0];

`ifdef DIV_JOB_DVZ_BYPASS_EN
    assign bypass = (head_b == '0);
`else
    assign bypass = 1'b0;
`endif

    div_job_fifo #(
        .W (2 * WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({in_a, in_b}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sequencer next-state: job launch, pulse protocol, wait/timeout and result handshake.
    always_comb begin
        state_d     = state_q;
        div_ld_d    = 1'b0;
        ldone_d     = 1'b0;
        start_d     = 1'b0;
        div_rst_d   = 1'b0;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        tmo_d       = tmo_q;
        res_valid_d = res_valid_q;
        res_q_d     = res_q_q;
        res_ov_d    = res_ov_q;
        res_dvz_d   = res_dvz_q;
        res_to_d    = res_to_q;
        job_count_d = job_count_q;
        fifo_pop    = 1'b0;

        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            job_count_d = job_count_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // Only one job in flight: wait until the previous result is taken.
                if (!fifo_empty && !res_valid_q) begin
                    fifo_pop = 1'b1;
                    if (bypass) begin
                        res_valid_d = 1'b1;
                        res_q_d     = '1;
                        res_ov_d    = 1'b0;
                        res_dvz_d   = 1'b1;
                        res_to_d    = 1'b0;
                    end else begin
                        div_a_d  = head_a;
                        div_b_d  = head_b;
                        div_ld_d = 1'b1;
                        state_d  = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                ldone_d = 1'b1;
                state_d = ST_LDONE;
            end
            ST_LDONE: begin
                start_d = 1'b1;
                state_d = ST_START;
            end
            ST_START: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion seen on the timeout cycle still counts as success.
                if (div_done) begin
                    res_valid_d = 1'b1;
                    res_q_d     = div_q;
                    res_ov_d    = div_ov;
                    res_dvz_d   = div_dvz;
                    res_to_d    = 1'b0;
                    state_d     = ST_IDLE;
                end else if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    res_valid_d = 1'b1;
                    res_q_d     = '0;
                    res_ov_d    = 1'b0;
                    res_dvz_d   = 1'b0;
                    res_to_d    = 1'b1;
                    div_rst_d   = 1'b1;
                    state_d     = ST_ABORT;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset holds the divider in reset and drops any pending result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            div_ld_q    <= 1'b0;
            ldone_q     <= 1'b0;
            start_q     <= 1'b0;
            div_rst_q   <= 1'b1;
            div_a_q     <= '0;
            div_b_q     <= '0;
            tmo_q       <= '0;
            res_valid_q <= 1'b0;
            res_q_q     <= '0;
            res_ov_q    <= 1'b0;
            res_dvz_q   <= 1'b0;
            res_to_q    <= 1'b0;
            job_count_q <= '0;
        end else begin
            state_q     <= state_d;
            div_ld_q    <= div_ld_d;
            ldone_q     <= ldone_d;
            start_q     <= start_d;
            div_rst_q   <= div_rst_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            tmo_q       <= tmo_d;
            res_valid_q <= res_valid_d;
            res_q_q     <= res_q_d;
            res_ov_q    <= res_ov_d;
            res_dvz_q   <= res_dvz_d;
            res_to_q    <= res_to_d;
            job_count_q <= job_count_d;
        end
    end

    assign div_ld_a         = div_ld_q;
    assign div_ld_b         = div_ld_q;
    assign div_loading_done = ldone_q;
    assign div_start        = start_q;
    assign div_rst          = div_rst_q;
    assign div_a            = div_a_q;
    assign div_b            = div_b_q;
    assign res_valid        = res_valid_q;
    assign res_q            = res_q_q;
    assign res_ov           = res_ov_q;
    assign res_dvz          = res_dvz_q;
    assign res_to           = res_to_q;
    assign job_count        = job_count_q;

endmodule

// File: tb/tb_div_job_controller.sv
// Bench for div_job_controller: directed jobs, a divider stub, a timeline
// model of the controller and directed literal expectations.
module tb_div_job_controller;

    localparam int W  = 10;
    localparam int T  = 16;
    localparam int NJ = 11;

    // Job table: dividend, divisor, stub latency (0 = never completes), stub quotient, stub overflow.
    localparam logic [9:0] JA [NJ] = '{10'h252, 10'h101, 10'h102, 10'h103, 10'h104, 10'h105,
                                       10'h106, 10'h107, 10'h108, 10'h109, 10'h10A};
    localparam logic [9:0] JB [NJ] = '{10'h064, 10'h011, 10'h022, 10'h033, 10'h044, 10'h055,
                                       10'h066, 10'h000, 10'h088, 10'h099, 10'h0AA};
    localparam int         JL [NJ] = '{12, 12, 5, 15, 16, 0, 4, 3, 0, 3, 3};
    localparam logic [9:0] JQ [NJ] = '{10'h0BC, 10'h011, 10'h022, 10'h033, 10'h044, 10'h055,
                                       10'h066, 10'h077, 10'h088, 10'h099, 10'h0AA};
    localparam logic       JO [NJ] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                       1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         div_ld_a, div_ld_b, div_loading_done, div_start, div_rst;
    logic [W-1:0] div_a, div_b;
    logic         div_done = 1'b0;
    logic [W-1:0] div_q = '0;
    logic         div_ov = 1'b0;
    logic         div_dvz = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_q;
    logic         res_ov, res_dvz, res_to;
    logic [7:0]   job_count;

    int n_tests = 0;
    int n_fail  = 0;
    int n_starts = 0;

    div_job_controller #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .div_ld_a         (div_ld_a),
        .div_ld_b         (div_ld_b),
        .div_loading_done (div_loading_done),
        .div_start        (div_start),
        .div_a            (div_a),
        .div_b            (div_b),
        .div_rst          (div_rst),
        .div_done         (div_done),
        .div_q            (div_q),
        .div_ov           (div_ov),
        .div_dvz          (div_dvz),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_q            (res_q),
        .res_ov           (res_ov),
        .res_dvz          (res_dvz),
        .res_to           (res_to),
        .job_count        (job_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [9:0] a);
        lat_of = 0;
        for (int i = 0; i < NJ; i++) if (JA[i] == a) lat_of = JL[i];
    endfunction

    function automatic logic [9:0] q_of(input logic [9:0] a);
        q_of = '0;
        for (int i = 0; i < NJ; i++) if (JA[i] == a) q_of = JQ[i];
    endfunction

    function automatic logic ov_of(input logic [9:0] a);
        ov_of = 1'b0;
        for (int i = 0; i < NJ; i++) if (JA[i] == a) ov_of = JO[i];
    endfunction

    // Divider stub: div_done pulses 'latency' cycles after the div_start cycle.
    logic [7:0] st_cd = '0;
    always @(posedge clk) begin
        if (div_rst) begin
            st_cd    <= '0;
            div_done <= 1'b0;
        end else if (div_start) begin
            st_cd    <= (lat_of(div_a) == 0) ? 8'd0 : 8'(lat_of(div_a) - 1);
            div_done <= 1'b0;
            div_q    <= q_of(div_a);
            div_ov   <= ov_of(div_a);
            div_dvz  <= (div_b == '0);
        end else if (st_cd != 0) begin
            st_cd    <= st_cd - 8'd1;
            div_done <= (st_cd == 8'd1);
        end else begin
            div_done <= 1'b0;
        end
    end

    always @(negedge clk) if (div_start) n_starts++;

    // Handshake log, used to confirm delivery order.
    logic [9:0] log_q [$];
    logic       log_to [$];
    logic       log_ov [$];
    always @(posedge clk) begin
        if (rst && res_valid && res_ready) begin
            log_q.push_back(res_q);
            log_to.push_back(res_to);
            log_ov.push_back(res_ov);
        end
    end

    // Timeline model: a queue of pending pairs and the edge number at which
    // the current job was launched; pulses and timeout are offsets from it.
    typedef struct packed { logic [9:0] a; logic [9:0] b; } pair_t;
    pair_t      mq [$];
    int         n, m_launch_e, m_abort_e;
    bit         m_active, m_rst_hold;
    logic [9:0] m_a, m_b, m_rq;
    logic       m_rv, m_rov, m_rdvz, m_rto;
    logic [7:0] m_jc;

    always @(posedge clk or negedge rst) begin
        bit    idle, old_rv;
        int    old_sz;
        pair_t e;
        if (!rst) begin
            mq.delete();
            n = 0; m_launch_e = -100; m_abort_e = -100;
            m_active = 0; m_rst_hold = 1;
            m_a = '0; m_b = '0; m_rq = '0;
            m_rv = 0; m_rov = 0; m_rdvz = 0; m_rto = 0; m_jc = '0;
        end else begin
            n++;
            m_rst_hold = 0;
            old_rv = m_rv;
            old_sz = mq.size();
            idle   = !m_active && (m_abort_e != n - 1);
            if (old_rv && res_ready) begin
                m_rv = 0;
                m_jc = m_jc + 8'd1;
            end
            if (m_active && n >= m_launch_e + 4) begin
                if (div_done) begin
                    m_rv = 1; m_rq = div_q; m_rov = div_ov; m_rdvz = div_dvz; m_rto = 0;
                    m_active = 0;
                end else if (n == m_launch_e + 3 + T) begin
                    m_rv = 1; m_rq = '0; m_rov = 0; m_rdvz = 0; m_rto = 1;
                    m_active = 0; m_abort_e = n;
                end
            end
            if (idle && old_sz > 0 && !old_rv) begin
                e = mq.pop_front();
`ifdef DIV_JOB_DVZ_BYPASS_EN
                if (e.b == '0) begin
                    m_rv = 1; m_rq = '1; m_rov = 0; m_rdvz = 1; m_rto = 0;
                end else
`endif
                begin
                    m_a = e.a; m_b = e.b; m_launch_e = n; m_active = 1;
                end
            end
            if (in_valid && old_sz < 2) mq.push_back({in_a, in_b});
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        chk("div_ld_a", 32'(div_ld_a), 32'(m_active && n == m_launch_e));
        chk("div_ld_b", 32'(div_ld_b), 32'(m_active && n == m_launch_e));
        chk("div_loading_done", 32'(div_loading_done), 32'(m_active && n == m_launch_e + 1));
        chk("div_start", 32'(div_start), 32'(m_active && n == m_launch_e + 2));
        chk("div_rst", 32'(div_rst), 32'(m_rst_hold || n == m_abort_e));
        chk("div_a", 32'(div_a), 32'(m_a));
        chk("div_b", 32'(div_b), 32'(m_b));
        chk("res_valid", 32'(res_valid), 32'(m_rv));
        chk("res_q", 32'(res_q), 32'(m_rq));
        chk("res_ov", 32'(res_ov), 32'(m_rov));
        chk("res_dvz", 32'(res_dvz), 32'(m_rdvz));
        chk("res_to", 32'(res_to), 32'(m_rto));
        chk("job_count", 32'(job_count), 32'(m_jc));
    end

    // Present job k until accepted; called and returning just after a rising edge.
    task automatic push(input int k);
        int g;
        bit rdy;
        g = 0;
        in_valid = 1'b1;
        in_a = JA[k];
        in_b = JB[k];
        do begin
            rdy = in_ready;
            @(posedge clk); #1;
            g++;
        end while (!rdy && g < 100);
        in_valid = 1'b0;
        chk("push accepted", 32'(rdy), 32'd1);
    endtask

    task automatic wait_rv(input int lim, input string nm);
        int g;
        g = 0;
        while (!res_valid && g < lim) begin
            @(posedge clk); #1;
            g++;
        end
        chk(nm, 32'(res_valid), 32'd1);
    endtask

    task automatic wait_jc(input int target, input int lim);
        int g;
        g = 0;
        while (job_count != 8'(target) && g < lim) begin
            @(posedge clk); #1;
            g++;
        end
        chk("job_count reached", 32'(job_count), 32'(target));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int s0;
        int g;

        // Reset held for three cycles.
        #2 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("reset div_rst", 32'(div_rst), 32'd1);
            chk("reset in_ready", 32'(in_ready), 32'd1);
            chk("reset res_valid", 32'(res_valid), 32'd0);
            chk("reset job_count", 32'(job_count), 32'd0);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("div_rst after release", 32'(div_rst), 32'd0);

        // Single job: pulse cycles 2/3/4, result on cycle 17.
        @(posedge clk); #1;
        push(0);
        @(negedge clk);
        @(negedge clk);
        chk("single ld_a cyc2", 32'(div_ld_a), 32'd1);
        chk("single ld_b cyc2", 32'(div_ld_b), 32'd1);
        chk("single div_a", 32'(div_a), 32'h252);
        @(negedge clk);
        chk("single ldone cyc3", 32'(div_loading_done), 32'd1);
        @(negedge clk);
        chk("single start cyc4", 32'(div_start), 32'd1);
        cyc = 4;
        while (!res_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("single res_valid cycle", 32'(cyc), 32'd17);
        chk("single res_q", 32'(res_q), 32'h0BC);
        chk("single res_to", 32'(res_to), 32'd0);
        @(posedge clk); #1 res_ready = 1'b1;
        @(posedge clk); #1 res_ready = 1'b0;
        chk("single res_valid cleared", 32'(res_valid), 32'd0);
        chk("single job_count", 32'(job_count), 32'd1);

        // Backpressure: results held, FIFO fills behind the pending result.
        push(1);
        push(2);
        push(3);
        wait_rv(60, "bp first result");
        chk("bp in_ready low", 32'(in_ready), 32'd0);
        chk("bp first res_q", 32'(res_q), 32'h011);
        repeat (3) @(posedge clk);
        #1;
        chk("bp res_q held", 32'(res_q), 32'h011);
        res_ready = 1'b1;
        push(4);
        wait_jc(5, 300);
        res_ready = 1'b0;
        chk("bp order 1", 32'(log_q[1]), 32'h011);
        chk("bp order 2", 32'(log_q[2]), 32'h022);
        chk("bp order 2 ov", 32'(log_ov[2]), 32'd1);
        chk("bp order 3", 32'(log_q[3]), 32'h033);
        chk("bp order 4 done beats timeout q", 32'(log_q[4]), 32'h044);
        chk("bp order 4 done beats timeout to", 32'(log_to[4]), 32'd0);

        // Timeout on a divider that never completes, then the next job runs.
        @(posedge clk); #1;
        push(5);
        push(6);
        wait_rv(80, "timeout result");
        chk("timeout res_to", 32'(res_to), 32'd1);
        chk("timeout res_q", 32'(res_q), 32'd0);
        chk("timeout div_rst pulse", 32'(div_rst), 32'd1);
        @(posedge clk); #1;
        chk("timeout div_rst one cycle", 32'(div_rst), 32'd0);
        res_ready = 1'b1;
        wait_jc(7, 100);
        res_ready = 1'b0;
        chk("timeout log to", 32'(log_to[5]), 32'd1);
        chk("after timeout q", 32'(log_q[6]), 32'h066);
        chk("after timeout to", 32'(log_to[6]), 32'd0);

        // Zero divisor.
        @(posedge clk); #1;
        s0 = n_starts;
        push(7);
        wait_rv(40, "zero div result");
`ifdef DIV_JOB_DVZ_BYPASS_EN
        chk("zero div no start", 32'(n_starts - s0), 32'd0);
        chk("zero div res_q", 32'(res_q), 32'h3FF);
        chk("zero div res_ov", 32'(res_ov), 32'd0);
`else
        chk("zero div started", 32'(n_starts - s0), 32'd1);
        chk("zero div res_q", 32'(res_q), 32'h077);
`endif
        chk("zero div res_dvz", 32'(res_dvz), 32'd1);
        chk("zero div res_to", 32'(res_to), 32'd0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 res_ready = 1'b0;
        chk("zero div job_count", 32'(job_count), 32'd8);

        // Reset while one job waits and another is queued.
        push(8);
        push(9);
        g = 0;
        while (!div_start && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        chk("midwait start seen", 32'(div_start), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midwait rst res_valid", 32'(res_valid), 32'd0);
        chk("midwait rst job_count", 32'(job_count), 32'd0);
        chk("midwait rst in_ready", 32'(in_ready), 32'd1);
        chk("midwait rst div_rst", 32'(div_rst), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("midwait fifo empty no launch", 32'(div_ld_a), 32'd0);
        end
        @(posedge clk); #1;
        push(10);
        @(negedge clk);
        @(negedge clk);
        chk("post reset launch ld_a", 32'(div_ld_a), 32'd1);
        chk("post reset div_a", 32'(div_a), 32'h10A);
        @(posedge clk); #1;
        wait_rv(40, "post reset result");
        chk("post reset res_q", 32'(res_q), 32'h0AA);
        res_ready = 1'b1;
        @(posedge clk); #1 res_ready = 1'b0;
        chk("post reset job_count", 32'(job_count), 32'd1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
